// File: rtl/irq_collector_pkg.sv
// ----------------------------------------------------------------------------
// irq_collector_pkg : shared line-count constants and width helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package irq_collector_pkg;

  // Shared with CP0's ir_map declaration
  localparam int IRQ_LINES = 30;
  localparam int IRQ_BASE  = 1;
  localparam int IRQ_TOP   = IRQ_BASE + IRQ_LINES - 1;

  typedef logic [IRQ_LINES-1:0] irq_vec_t;

  // Bits needed to hold value; never less than one
  function automatic int get_width(input int value);
    int w;
    w = 1;
    for (int b = 1; b < 32; b++) begin
      if ((value >> b) != 0) w = b + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_line.sv
// ----------------------------------------------------------------------------
// irq_line : normalize, synchronize, optionally filter (IRQ_FILTER_EN) and
//            deliver one interrupt line as an edge pulse or a level.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_line
  import irq_collector_pkg::*;
#(
  parameter bit EDGE          = 1'b0,
  parameter bit INVERT        = 1'b0,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_raw,
  output logic irq_out,
  output logic level
);

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 4095) begin : g_bad_filter_cycles
    $error("irq_line: FILTER_CYCLES out of range 1..4095");
  end

  logic s1_d, s1_q;
  logic s2_d, s2_q;
  logic stable;
  logic stable_prev_d, stable_prev_q;
  logic ir_map_d, ir_map_q;

  // Inversion precedes the synchronizer so reset-cleared flops read inactive
  always_comb begin
    s1_d          = irq_raw ^ INVERT;
    s2_d          = s1_q;
    stable_prev_d = stable;
    ir_map_d      = EDGE ? (stable & ~stable_prev_q) : stable;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      stable_prev_q <= 1'b0;
      ir_map_q      <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      stable_prev_q <= stable_prev_d;
      ir_map_q      <= ir_map_d;
    end
  end

`ifdef IRQ_FILTER_EN
  localparam int              CNT_W   = get_width(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic             stable_d, stable_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // cnt tops out at CNT_MAX: the matching edge either accepts or resets it
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = s2_q;
      else                  cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
`else
  assign stable = s2_q;
`endif

  assign irq_out = ir_map_q;
  assign level   = stable;

endmodule

`default_nettype wire

// File: rtl/irq_collector.sv
// ----------------------------------------------------------------------------
// irq_collector : conditions the device interrupt lines into CP0 ir_map;
//                 glitch filter compiled in with IRQ_FILTER_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_collector
  import irq_collector_pkg::*;
#(
  parameter irq_vec_t EDGE_MASK     = '0,
  parameter irq_vec_t ACTIVE_LOW    = '0,
  parameter int       FILTER_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IRQ_TOP:IRQ_BASE] irq_in,
  output logic [IRQ_TOP:IRQ_BASE] ir_map,
  output logic [IRQ_TOP:IRQ_BASE] irq_level
);

  for (genvar i = 0; i < IRQ_LINES; i++) begin : g_line
    irq_line #(
      .EDGE          (EDGE_MASK[i]),
      .INVERT        (ACTIVE_LOW[i]),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_line (
      .clk     (clk),
      .rst     (rst),
      .irq_raw (irq_in[IRQ_BASE+i]),
      .irq_out (ir_map[IRQ_BASE+i]),
      .level   (irq_level[IRQ_BASE+i])
    );
  end

endmodule

`default_nettype wire
